norm8_seq: RTL and testbench

Sequential 8-bit normalizer: the inverse companion of the combinational barrel shifter in the shifter datapath. Given a word, it finds the shift amount and direction that bring the first set bit to the edge, and returns both the normalized word and the amount. It applies one single-bit shift per clock under a start/done handshake. Its shamt/dir pair, fed back into the barrel shifter with the opposite direction, reconstructs the original operand.

---
 rtl/norm8_seq.sv | 125 ++++++++++++
 tb/tb_norm8_seq.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/norm8_seq.sv
// ---------------------------------------------------------------------------
// norm8_seq
//
// Sequential 8-bit normalizer. It finds how far an operand must be shifted so
// that its first set bit reaches the edge: bit 7 for left normalize, or bit 0
// for right normalize. It returns the normalized word and the shift amount.
// One single-bit logical shift is applied per clock, under a start/done
// handshake.
//
// Feeding shamt back into the barrel shifter with the opposite direction
// reconstructs the original operand.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous, active-high reset
//   start  in   request; accepted on a rising edge only while busy=0
//   din    in   [7:0] operand; captured on the accepting edge
//   dir    in   captured with din; 0 = left-normalize, 1 = right-normalize
//   busy   out  high from the accepting edge until the return to IDLE
//   done   out  one-cycle pulse; dout/shamt/zero are valid in this cycle
//   dout   out  [7:0] normalized word; holds until the next result
//   shamt  out  [2:0] number of single-bit shifts applied
//   zero   out  operand was 0x00
// ---------------------------------------------------------------------------
module norm8_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] din,
    input  logic       dir,
    output logic       busy,
    output logic       done,
    output logic [7:0] dout,
    output logic [2:0] shamt,
    output logic       zero
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t     r_state;
    logic [7:0] r_work;
    logic [2:0] r_cnt;
    logic       r_dir;
    logic       r_busy;
    logic       r_done;
    logic [7:0] r_dout;
    logic [2:0] r_shamt;
    logic       r_zero;

    // The bit that must be set for the word to count as normalized.
    logic w_edge_bit;
    assign w_edge_bit = r_dir ? r_work[0] : r_work[7];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_work  <= 8'h00;
            r_cnt   <= 3'd0;
            r_dir   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dout  <= 8'h00;
            r_shamt <= 3'd0;
            r_zero  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_work  <= din;
                        r_dir   <= dir;
                        r_cnt   <= 3'd0;
                        r_busy  <= 1'b1;
                        r_state <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    if (r_work == 8'h00) begin
                        // An empty operand has no bit to bring to the edge.
                        r_zero  <= 1'b1;
                        r_dout  <= 8'h00;
                        r_shamt <= 3'd0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (w_edge_bit) begin
                        r_zero  <= 1'b0;
                        r_dout  <= r_work;
                        r_shamt <= r_cnt;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        // A nonzero word reaches the edge within 7 shifts,
                        // so the 3-bit counter cannot wrap.
                        r_work <= r_dir ? {1'b0, r_work[7:1]} : {r_work[6:0], 1'b0};
                        r_cnt  <= r_cnt + 3'd1;
                    end
                end

                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign dout  = r_dout;
    assign shamt = r_shamt;
    assign zero  = r_zero;

endmodule

// File: tb/tb_norm8_seq.sv
// ---------------------------------------------------------------------------
// tb_norm8_seq
//
// Self-checking bench for norm8_seq. A reference model computes the expected
// results. It locates the first set bit by position and derives shamt, dout
// and the done latency arithmetically from that position.
// ---------------------------------------------------------------------------
module tb_norm8_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] din;
    logic       dir;
    logic       busy;
    logic       done;
    logic [7:0] dout;
    logic [2:0] shamt;
    logic       zero;

    int n_tests;
    int n_fail;

    norm8_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .din   (din),
        .dir   (dir),
        .busy  (busy),
        .done  (done),
        .dout  (dout),
        .shamt (shamt),
        .zero  (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result packed as {zero, shamt, dout}.
    function automatic logic [11:0] ref_norm(input logic [7:0] d, input logic dr);
        int pos;
        int k;
        logic [7:0] w;
        if (d == 8'h00) return {1'b1, 3'd0, 8'h00};
        pos = -1;
        if (!dr) begin
            for (int i = 0; i < 8; i++) if (d[i]) pos = i;       // highest set bit
            k = 7 - pos;
            w = d << k;
        end else begin
            for (int i = 7; i >= 0; i--) if (d[i]) pos = i;      // lowest set bit
            k = pos;
            w = d >> k;
        end
        return {1'b0, 3'(k), w};
    endfunction

    function automatic int ref_lat(input logic [7:0] d, input logic dr);
        logic [11:0] r;
        r = ref_norm(d, dr);
        return int'(r[10:8]) + 1;
    endfunction

    // Issues one operation from IDLE and waits for its done pulse.
    // lat is the edge number (accepting edge = 0) after which done was seen,
    // or 20 on timeout. bcnt counts cycles with busy high.
    task automatic run_op(input logic [7:0] d, input logic dr, output int lat, output int bcnt);
        @(negedge clk);
        start = 1'b1;
        din   = d;
        dir   = dr;
        @(posedge clk);
        #1;
        start = 1'b0;
        din   = 8'($urandom);
        dir   = 1'($urandom);
        bcnt  = busy ? 1 : 0;
        lat   = 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) bcnt++;
        end
        if (done) begin
            @(posedge clk);
            #1;
            if (busy) bcnt++;
        end
    endtask

    task automatic check_op(input string name, input logic [7:0] d, input logic dr,
                            input int lat);
        logic [11:0] exp_r;
        int          exp_l;
        exp_r = ref_norm(d, dr);
        exp_l = ref_lat(d, dr);
        n_tests++;
        if ({zero, shamt, dout} !== exp_r) begin
            n_fail++;
            $display("FAIL %s din=%02h dir=%0d: got zero=%0d shamt=%0d dout=%02h, want zero=%0d shamt=%0d dout=%02h",
                     name, d, dr, zero, shamt, dout, exp_r[11], exp_r[10:8], exp_r[7:0]);
        end
        n_tests++;
        if (lat !== exp_l) begin
            n_fail++;
            $display("FAIL %s_latency din=%02h dir=%0d: got %0d, want %0d", name, d, dr, lat, exp_l);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        start = 1'b0;
        din   = 8'h00;
        dir   = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({busy, done, dout, shamt, zero} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%0d done=%0d dout=%02h shamt=%0d zero=%0d, want all 0",
                     busy, done, dout, shamt, zero);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_hold: got busy=%0d done=%0d, want 0 0", busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        int lat;
        int bcnt;
        logic [7:0] dv [5] = '{8'h01, 8'hB4, 8'hB4, 8'h00, 8'h00};
        logic       rv [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            run_op(dv[i], rv[i], lat, bcnt);
            check_op("directed", dv[i], rv[i], lat);
            n_tests++;
            if (bcnt !== ref_lat(dv[i], rv[i]) + 1) begin
                n_fail++;
                $display("FAIL busy_cycles din=%02h dir=%0d: got %0d, want %0d",
                         dv[i], rv[i], bcnt, ref_lat(dv[i], rv[i]) + 1);
            end
        end
    endtask

    task automatic test_random();
        int lat;
        int bcnt;
        logic [7:0] d;
        logic       r;
        for (int i = 0; i < 40; i++) begin
            d = 8'($urandom);
            // Bias toward sparse words so that long shift counts appear.
            if (i % 3 == 0) d = 8'h01 << $urandom_range(0, 7);
            r = 1'($urandom);
            run_op(d, r, lat, bcnt);
            check_op("random", d, r, lat);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        start = 1'b1;
        din   = 8'h01;
        dir   = 1'b1;
        @(posedge clk);      // edge 0: accept first op
        #1;
        din = 8'h10;
        dir = 1'b1;
        @(posedge clk);      // edge 1: result of first op
        #1;
        n_tests++;
        if ({done, dout, shamt} !== {1'b1, 8'h01, 3'd0}) begin
            n_fail++;
            $display("FAIL b2b_first: got done=%0d dout=%02h shamt=%0d, want 1 01 0", done, dout, shamt);
        end
        @(posedge clk);      // edge 2: DONE -> IDLE, start ignored
        #1;
        n_tests++;
        if ({busy, done, dout} !== {1'b0, 1'b0, 8'h01}) begin
            n_fail++;
            $display("FAIL b2b_ignored: got busy=%0d done=%0d dout=%02h, want 0 0 01", busy, done, dout);
        end
        @(posedge clk);      // edge 3: second op accepted
        #1;
        start = 1'b0;
        n_tests++;
        if ({busy, dout, shamt} !== {1'b1, 8'h01, 3'd0}) begin
            n_fail++;
            $display("FAIL b2b_accept: got busy=%0d dout=%02h shamt=%0d, want 1 01 0", busy, dout, shamt);
        end
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (!done && dout !== 8'h01) begin
                n_tests++;
                n_fail++;
                $display("FAIL b2b_hold: got dout=%02h, want 01", dout);
            end
        end
        check_op("b2b_second", 8'h10, 1'b1, lat);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midop();
        int lat;
        int bcnt;
        int seen_done;
        @(negedge clk);
        start = 1'b1;
        din   = 8'h02;
        dir   = 1'b0;
        @(posedge clk);      // edge 0
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        n_tests++;
        if ({busy, done, dout, shamt, zero} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_midop: got busy=%0d done=%0d dout=%02h shamt=%0d zero=%0d, want all 0",
                     busy, done, dout, shamt, zero);
        end
        seen_done = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (done) seen_done++;
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (done || busy) seen_done++;
        end
        n_tests++;
        if (seen_done !== 0) begin
            n_fail++;
            $display("FAIL reset_no_done: got %0d cycles with done/busy, want 0", seen_done);
        end
        run_op(8'h40, 1'b0, lat, bcnt);
        check_op("after_reset", 8'h40, 1'b0, lat);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
